// File: rtl/hud_text_writer.sv
// hud_text_writer: writes the HUD labels after reset, then services score/timer
// update requests by writing fixed-width decimal digits into the text buffer.
module hud_text_writer #(
    parameter int ADDR_W     = 6,
    parameter int SCORE_BASE = 0,
    parameter int TIME_BASE  = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              score_upd,
    input  logic [15:0]       score_val,
    input  logic              time_upd,
    input  logic [7:0]        time_val,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_char,
    output logic              busy,
    output logic              done_score,
    output logic              done_time
);
    typedef enum logic [1:0] {INIT, IDLE, CONV, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        lbl_q, lbl_d, cnt_q, cnt_d;
    logic [2:0]        widx_q, widx_d;
    logic [15:0]       rem_q, rem_d, weight;
    logic              sp_q, sp_d, tp_q, tp_d, rr_time_q, rr_time_d, time_cv_q, time_cv_d;
    logic              wr_en_q, wr_en_d, busy_q, busy_d;
    logic              done_score_q, done_score_d, done_time_q, done_time_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, lbl_addr, dig_addr;
    logic [6:0]        wr_char_q, wr_char_d, lbl_char;
    logic              gs, gt;

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_char    = wr_char_q;
    assign busy       = busy_q;
    assign done_score = done_score_q;
    assign done_time  = done_time_q;

    // A timer conversion starts at weight index 2 so both requesters share one weight table.
    assign weight   = widx_q == 3'd0 ? 16'd10000 : widx_q == 3'd1 ? 16'd1000 :
                      widx_q == 3'd2 ? 16'd100   : widx_q == 3'd3 ? 16'd10 : 16'd1;
    assign dig_addr = time_cv_q ? ADDR_W'(TIME_BASE + 3 + int'(widx_q))
                                : ADDR_W'(SCORE_BASE + 6 + int'(widx_q));
    assign lbl_addr = lbl_q < 4'd6 ? ADDR_W'(SCORE_BASE + int'(lbl_q))
                                   : ADDR_W'(TIME_BASE + int'(lbl_q) - 6);
    assign gs = sp_q & (~tp_q | rr_time_q);
    assign gt = tp_q & ~gs;

    always_comb begin
        lbl_char = 7'd62;
        case (lbl_q)
            4'd0:    lbl_char = 7'd28;
            4'd1:    lbl_char = 7'd38;
            4'd2:    lbl_char = 7'd50;
            4'd3:    lbl_char = 7'd53;
            4'd4:    lbl_char = 7'd40;
            4'd6:    lbl_char = 7'd29;
            4'd7:    lbl_char = 7'd44;
            4'd8:    lbl_char = 7'd48;
            4'd9:    lbl_char = 7'd40;
            default: lbl_char = 7'd62;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lbl_d        = lbl_q;
        sp_d         = sp_q | score_upd;
        tp_d         = tp_q | time_upd;
        rr_time_d    = rr_time_q;
        time_cv_d    = time_cv_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        widx_d       = widx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_char_d    = wr_char_q;
        done_score_d = 1'b0;
        done_time_d  = 1'b0;
        case (state_q)
            INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = lbl_addr;
                wr_char_d = lbl_char;
                lbl_d     = lbl_q + 4'd1;
                if (lbl_q == 4'd10) begin
                    state_d = IDLE;
                    lbl_d   = 4'd0;
                    sp_d    = 1'b1;
                    tp_d    = 1'b1;
                end
            end
            IDLE: begin
                if (gs | gt) begin
                    state_d   = CONV;
                    time_cv_d = gt;
                    rr_time_d = gt;
                    rem_d     = gt ? {8'd0, time_val} : score_val;
                    widx_d    = gt ? 3'd2 : 3'd0;
                    cnt_d     = 4'd0;
                    // A pulse landing on the grant cycle keeps the flag set.
                    sp_d      = score_upd | (sp_q & ~gs);
                    tp_d      = time_upd | (tp_q & ~gt);
                end
            end
            CONV: begin
                if (rem_q >= weight) begin
                    rem_d = rem_q - weight;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_char_d = {3'd0, cnt_q};
                    wr_addr_d = dig_addr;
                    cnt_d     = 4'd0;
                    widx_d    = widx_q + 3'd1;
                    if (widx_q == 3'd4) state_d = DONE;
                end
            end
            DONE: begin
                done_score_d = ~time_cv_q;
                done_time_d  = time_cv_q;
                state_d      = IDLE;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= INIT;
            lbl_q        <= '0;
            sp_q         <= 1'b0;
            tp_q         <= 1'b0;
            rr_time_q    <= 1'b1;
            time_cv_q    <= 1'b0;
            rem_q        <= '0;
            cnt_q        <= '0;
            widx_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_char_q    <= '0;
            busy_q       <= 1'b0;
            done_score_q <= 1'b0;
            done_time_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lbl_q        <= lbl_d;
            sp_q         <= sp_d;
            tp_q         <= tp_d;
            rr_time_q    <= rr_time_d;
            time_cv_q    <= time_cv_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_char_q    <= wr_char_d;
            busy_q       <= busy_d;
            done_score_q <= done_score_d;
            done_time_q  <= done_time_d;
        end
    end
endmodule

// File: tb/tb_hud_text_writer.sv
// tb_hud_text_writer: scoreboard bench; a decimal reference model predicts every
// buffer write and done pulse, a monitor pops and compares them.
module tb_hud_text_writer;
    localparam int SB = 0;
    localparam int TB = 16;

    logic       clk = 1'b0, resetN = 1'b0;
    logic       score_upd = 1'b0, time_upd = 1'b0;
    logic [15:0] score_val = '0;
    logic [7:0]  time_val = '0;
    logic       wr_en, busy, done_score, done_time;
    logic [5:0] wr_addr;
    logic [6:0] wr_char;

    typedef struct {int kind; int addr; int ch;} ev_t;
    ev_t sb[$];
    int checks = 0, failures = 0, nwrites = 0;
    bit rr_time = 1'b1;

    hud_text_writer #(.ADDR_W(6), .SCORE_BASE(SB), .TIME_BASE(TB)) dut (
        .clk(clk), .resetN(resetN), .score_upd(score_upd), .score_val(score_val),
        .time_upd(time_upd), .time_val(time_val), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .busy(busy), .done_score(done_score), .done_time(done_time));

    always #5 clk = ~clk;

    task automatic chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", n, act, exp);
        end
    endtask

    task automatic check_ev(int k, int a, int c);
        ev_t e;
        checks++;
        if (k == 0) nwrites++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected kind=%0d addr=%0d char=%0d expected=none", k, a, c);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || (k == 0 && (e.addr != a || e.ch != c))) begin
                failures++;
                $display("FAIL sb_event got kind=%0d addr=%0d char=%0d expected kind=%0d addr=%0d char=%0d",
                         k, a, c, e.kind, e.addr, e.ch);
            end
        end
    endtask

    always @(negedge clk) if (resetN) begin
        if (wr_en) check_ev(0, int'(wr_addr), int'(wr_char));
        if (done_score) check_ev(1, 0, 0);
        if (done_time) check_ev(2, 0, 0);
    end

    task automatic push_labels();
        int lc[11] = '{28, 38, 50, 53, 40, 62, 29, 44, 48, 40, 62};
        for (int i = 0; i < 11; i++) sb.push_back('{0, i < 6 ? SB + i : TB + i - 6, lc[i]});
    endtask

    // Decimal digits computed by plain division, most significant first.
    task automatic push_conv(bit t, int v);
        int n = t ? 3 : 5;
        int p;
        for (int i = 0; i < n; i++) begin
            p = 1;
            for (int j = 0; j < n - 1 - i; j++) p *= 10;
            sb.push_back('{0, (t ? TB + 5 : SB + 6) + i, (v / p) % 10});
        end
        sb.push_back('{t ? 2 : 1, 0, 0});
    endtask

    task automatic issue(bit s, bit t, int sv, int tv);
        @(negedge clk);
        score_val = 16'(sv);
        time_val  = 8'(tv);
        score_upd = s;
        time_upd  = t;
        if (s && t) begin
            if (rr_time) begin push_conv(0, sv); push_conv(1, tv); end
            else begin push_conv(1, tv); push_conv(0, sv); end
        end else if (s) begin
            push_conv(0, sv);
            rr_time = 1'b0;
        end else if (t) begin
            push_conv(1, tv);
            rr_time = 1'b1;
        end
        @(negedge clk);
        score_upd = 1'b0;
        time_upd  = 1'b0;
    endtask

    task automatic wait_idle(string n);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        if (i == 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout pending=%0d expected=0", n, sb.size());
        end
    endtask

    task automatic chk_reset_outputs(string n);
        chk({n, "_wr_en"}, int'(wr_en), 0);
        chk({n, "_wr_addr"}, int'(wr_addr), 0);
        chk({n, "_wr_char"}, int'(wr_char), 0);
        chk({n, "_busy"}, int'(busy), 0);
        chk({n, "_done_score"}, int'(done_score), 0);
        chk({n, "_done_time"}, int'(done_time), 0);
    endtask

    initial begin
        int cnt, base, i;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst0");
        push_labels();
        push_conv(0, 0);
        push_conv(1, 0);
        rr_time = 1'b1;
        resetN = 1'b1;
        wait_idle("init");

        issue(1, 0, 12345, 0);
        cnt = 0;
        for (i = 0; i < 200; i++) begin
            if (busy) cnt++;
            if (done_score) break;
            @(negedge clk);
        end
        chk("busy_cycles_12345", cnt, 21);
        wait_idle("score12345");

        issue(1, 1, 65535, 255);
        wait_idle("both_max");

        @(negedge clk);
        time_val = 8'd42;
        time_upd = 1'b1;
        push_conv(1, 7);
        rr_time = 1'b1;
        @(negedge clk);
        time_upd = 1'b0;
        time_val = 8'd7;
        wait_idle("time_late");

        for (int k = 0; k < 20; k++) begin
            int m = $urandom_range(0, 2);
            issue(m != 1, m != 0, $urandom_range(0, 65535), $urandom_range(0, 255));
            wait_idle("random");
        end

        base = nwrites;
        issue(1, 0, 12345, int'(time_val));
        for (i = 0; i < 200 && nwrites < base + 2; i++) @(negedge clk);
        chk("mid_digits_seen", nwrites - base, 2);
        #1 resetN = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        sb.delete();
        repeat (3) @(negedge clk);
        chk("rst_hold_wr_en", int'(wr_en), 0);
        push_labels();
        push_conv(0, 12345);
        push_conv(1, int'(time_val));
        rr_time = 1'b1;
        resetN = 1'b1;
        wait_idle("reinit");

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hud_text_writer.md
Name: hud_text_writer

Overview:
Controller that owns the write port of the HUD character buffer, the text RAM read by the character renderer. It writes the static labels "Score:" and "Time:" once after reset. It then arbitrates between score-update and timer-update requesters and converts each binary value to fixed-width decimal. Every character is written as a 7-bit char_name_t code from char_enum_pkg.

Parameters:
ADDR_W, 6, width of text-buffer address.
SCORE_BASE, 0, buffer address of the 'S' in "Score:". Score digits go at SCORE_BASE+6..+10.
TIME_BASE, 16, buffer address of the 'T' in "Time:". Timer digits go at TIME_BASE+5..+7.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
score_upd  in  1  one-cycle pulse: score changed
score_val  in  16  current score, unsigned
time_upd  in  1  one-cycle pulse: timer changed
time_val  in  8  current timer value, unsigned
wr_en  out  1  text-buffer write strobe
wr_addr  out  ADDR_W  text-buffer address
wr_char  out  7  char_name_t code to write
busy  out  1  high whenever the FSM is not in IDLE
done_score  out  1  one-cycle pulse: score digits fully written
done_time  out  1  one-cycle pulse: timer digits fully written

Behaviour:
- Reset (async, resetN=0): all outputs 0, both pending flags 0, rr_last=TIME, state=INIT, label index 0.
- Outputs are registered; wr_en/wr_addr/wr_char change together.
- Enum codes used:
  - CHAR_0..CHAR_9 = 0..9.
  - S=28, T=29, c=38, e=40, i=44, m=48, o=50, r=53, COLON=62.
- INIT:
  - 11 consecutive cycles with wr_en=1.
  - Writes S,c,o,r,e,COLON at SCORE_BASE+0..5.
  - Then writes T,i,m,e,COLON at TIME_BASE+0..4.
  - Then sets both pending flags and goes to IDLE.
  - score_upd/time_upd pulses during INIT are absorbed; pending is already set.
- Pending flags:
  - An upd pulse sets that requester's flag in any state.
  - The flag is cleared only on grant.
  - If a pulse and a grant of the same requester coincide, set wins: the requester is serviced again later.
- IDLE (wr_en=0):
  - Only one flag pending: grant it.
  - Both pending: grant the one not equal to rr_last.
  - On grant, latch the live value (score_val or time_val at the grant cycle, not at the pulse) into rem.
  - Also on grant: load digit weights (score: 10000,1000,100,10,1; time: 100,10,1), cnt=0, clear flag, update rr_last, go to CONV.
- CONV, one action per cycle:
  - If rem >= weight: rem -= weight, cnt++, wr_en=0.
  - Else: wr_en=1, wr_char=cnt, wr_addr=next digit address; then cnt=0 and advance weight.
  - After the last digit write, go to DONE.
- CONV latency is the sum of the decimal digits plus the digit count, in cycles.
- Leading zeros are always written: fixed width, 5 digits for score, 3 for time.
- DONE: one cycle, wr_en=0, pulse done_score or done_time, return to IDLE.
- busy=1 in INIT, CONV and DONE.
- Input changes after grant do not affect the conversion in progress.
- Reset mid-CONV aborts without further writes. After release, the full INIT sequence repeats.
- wr_char never outputs CHAR_NULL or codes above 62.

Test Plan:
- Reset release, score_val=0, time_val=0:
  - 11 label writes: addr 0..5 codes 28,38,50,53,40,62; addr 16..20 codes 29,44,48,40,62.
  - Then score digits 0,0,0,0,0 at addr 6..10 with done_score.
  - Then time digits 0,0,0 at 21..23 with done_time.
- score_val=12345, score_upd pulse in IDLE:
  - Writes 1,2,3,4,5 at addr 6..10.
  - Exactly 20 CONV cycles, done_score on the next cycle, busy high throughout.
- score_upd and time_upd in the same cycle, rr_last=SCORE: time is serviced first, then score. No interleaved writes.
- Boundary values, score_val=65535 and time_val=255:
  - Score writes 6,5,5,3,5 at 6..10; time writes 2,5,5 at 21..23.
  - No overflow and no code above 9.
- time_upd pulse with time_val=42, then time_val changed to 7 one cycle before grant: writes 0,0,7 (the value at grant is used).
- resetN low midway through converting 12345 (after 2 digits written):
  - All outputs 0 immediately; no further digit writes.
  - After release, INIT labels are rewritten from addr 0.
